// File: rtl/usbls_xact_ctrl.sv
// usbls_xact_ctrl: host-side low-speed USB IN/OUT transaction sequencer.
// Sends token/DATA/ACK through the TX path, gates the receiver, tracks DATA0/1 and retries on NAK or timeout.
module usbls_xact_ctrl #(
    parameter int HS_TIMEOUT   = 24,
    parameter int DATA_TIMEOUT = 128,
    parameter int MAX_RETRY    = 3,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic       toggle_clr,
    output logic       tx_start,
    output logic [1:0] tx_kind,
    input  logic       tx_done,
    output logic       rx_en,
    input  logic [3:0] rx_pid_flag,
    input  logic       rx_complete,
    input  logic [3:0] rx_byte_size,
    output logic       status_valid,
    output logic [1:0] status_code,
    output logic [3:0] status_bytes,
    output logic       toggle
);
    localparam int TW = $clog2(DATA_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] HS_LAST   = TW'(HS_TIMEOUT - 1);
    localparam logic [TW-1:0] DATA_LAST = TW'(DATA_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_TOK   = 4'd1;
    localparam logic [3:0] S_TXD   = 4'd2;
    localparam logic [3:0] S_RXW   = 4'd3;
    localparam logic [3:0] S_RXD   = 4'd4;
    localparam logic [3:0] S_ACKS  = 4'd5;
    localparam logic [3:0] S_RETRY = 4'd6;
    localparam logic [3:0] S_GAP   = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]    state, nxt;
    logic          dir, tog, sent, rx_tog, dup, last_nak;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [GW-1:0] gap;
    logic [3:0]    bytes_q;

    // sent marks that the current packet's start pulse has already gone out
    always_comb begin
        cmd_ready    = state == S_IDLE;
        tx_start     = (state == S_TOK || state == S_TXD || state == S_ACKS) && !sent;
        tx_kind      = state == S_TXD ? (tog ? 2'd2 : 2'd1) : state == S_ACKS ? 2'd3 : 2'd0;
        rx_en        = state == S_RXW || state == S_RXD;
        status_valid = state == S_DONE;
        toggle       = tog;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            nxt          <= S_IDLE;
            dir          <= 1'b0;
            tog          <= 1'b0;
            sent         <= 1'b0;
            rx_tog       <= 1'b0;
            dup          <= 1'b0;
            last_nak     <= 1'b0;
            timer        <= '0;
            retry        <= '0;
            gap          <= '0;
            bytes_q      <= '0;
            status_code  <= 2'd0;
            status_bytes <= 4'd0;
        end else begin
            sent  <= tx_start | (sent & ~tx_done);
            gap   <= state == S_GAP ? gap + 1'b1 : '0;
            timer <= timer + TW'(~&timer);
            case (state)
                S_IDLE: begin
                    if (toggle_clr) tog <= 1'b0;
                    if (cmd_valid) begin
                        dir   <= cmd_dir;
                        state <= S_TOK;
                    end
                end
                S_TOK: if (tx_done) begin
                    state <= S_GAP;
                    nxt   <= dir ? S_RXW : S_TXD;
                end
                S_TXD: if (tx_done) begin
                    state <= S_GAP;
                    nxt   <= S_RXW;
                end
                S_GAP: if (gap == GAP_LAST) begin
                    state <= nxt;
                    timer <= '0;
                end
                // priority: NAK, expected flag, unexpected flag or timer expiry
                S_RXW: begin
                    if (rx_pid_flag[0]) begin
                        last_nak <= 1'b1;
                        state    <= S_RETRY;
                    end else if (dir && |rx_pid_flag[3:2]) begin
                        rx_tog <= rx_pid_flag[2];
                        timer  <= '0;
                        state  <= S_RXD;
                    end else if (!dir && rx_pid_flag[1]) begin
                        status_code  <= 2'd0;
                        status_bytes <= 4'd0;
                        tog          <= ~tog;
                        state        <= S_DONE;
                    end else if (|rx_pid_flag || timer == HS_LAST) begin
                        last_nak <= 1'b0;
                        state    <= S_RETRY;
                    end
                end
                S_RXD: begin
                    if (rx_complete) begin
                        dup     <= rx_tog != tog;
                        bytes_q <= rx_byte_size;
                        state   <= S_GAP;
                        nxt     <= S_ACKS;
                    end else if (timer == DATA_LAST) begin
                        last_nak <= 1'b0;
                        state    <= S_RETRY;
                    end
                end
                S_ACKS: if (tx_done) begin
                    status_code  <= dup ? 2'd3 : 2'd0;
                    status_bytes <= dup ? 4'd0 : bytes_q;
                    if (!dup) tog <= ~tog;
                    state <= S_DONE;
                end
                S_RETRY: begin
                    if (retry < RETRY_MAX) begin
                        retry <= retry + 1'b1;
                        state <= S_GAP;
                        nxt   <= S_TOK;
                    end else begin
                        status_code  <= last_nak ? 2'd1 : 2'd2;
                        status_bytes <= 4'd0;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    retry <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
